// File: rtl/cla_serial_add_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit carry-lookahead slice reused once per nibble, LSB first,
// with valid/ready handshakes on the operand and result sides and registered outputs.

module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o,
  output logic       pg_o,
  output logic       gg_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Lookahead carries expanded directly from propagate/generate terms.
  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    gg_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg_o = &p;
    c[4] = gg_o | (pg_o & c_i);
    s_o  = p ^ c[3:0];
    c_o  = c[4];
  end
endmodule

module cla_serial_add_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [KW-1:0]     k_q, k_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [3:0]        nib_a, nib_b, slice_s;
  logic              slice_co;
  logic              slice_pg_unused, slice_gg_unused;

  // Operand nibble selected by the step counter.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (k_q == KW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  cla_4bit u_slice (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .c_i  (carry_q),
    .s_o  (slice_s),
    .c_o  (slice_co),
    .pg_o (slice_pg_unused),
    .gg_o (slice_gg_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      work_q      <= work_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      k_q         <= k_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    k_d     = k_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = '0;
          work_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(N); i++) begin
          if (k_q == KW'(i)) work_d[4*i +: 4] = slice_s;
        end
        carry_d = slice_co;
        if (k_q == KW'(N - 1)) begin
          sum_d   = work_d;
          cout_d  = slice_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Scoreboard bench for cla_serial_add_ctrl: WIDTH=32 and WIDTH=4 instances, directed and random ops.

module tb_cla_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic        in_valid = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  wire         out_ready;
  logic        in_ready, out_valid, cout, ovf, busy;
  logic [31:0] sum;
  logic        rnd_mode = 1'b0, rnd_rdy = 1'b1, dir_rdy = 1'b1;
  assign out_ready = rnd_mode ? rnd_rdy : dir_rdy;

  logic        in_valid4 = 1'b0, cin4 = 1'b0, out_ready4 = 1'b1;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, cout4, ovf4, busy4;
  logic [3:0]  sum4;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;
  exp_t sb32[$];
  exp_t sb4[$];

  cla_serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .busy(busy)
  );

  cla_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4),
    .ovf(ovf4), .busy(busy4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor for the 32-bit instance: pops on every result handshake.
  logic ov_prev = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("ready_vs_busy", 64'(in_ready), 64'(!busy));
      if (out_valid && !ov_prev) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb32.size() == 0) fail_now("unexpected_result");
        else begin
          e = sb32.pop_front();
          chk("sum32", 64'(sum), 64'(e.s));
          chk("cout32", 64'(cout), 64'(e.c));
          chk("ovf32", 64'(ovf), 64'(e.o));
          chk("latency32", 64'(rise_cyc - e.acc), 64'(8));
        end
      end
    end
    ov_prev = out_valid;
  end

  logic ov4_prev = 1'b0;
  int   rise4_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid4 && !ov4_prev) rise4_cyc = cyc;
      if (out_valid4 && out_ready4) begin
        if (sb4.size() == 0) fail_now("unexpected_result4");
        else begin
          e = sb4.pop_front();
          chk("sum4", 64'(sum4), 64'(e.s));
          chk("cout4", 64'(cout4), 64'(e.c));
          chk("ovf4", 64'(ovf4), 64'(e.o));
          chk("latency4", 64'(rise4_cyc - e.acc), 64'(1));
        end
      end
    end
    ov4_prev = out_valid4;
  end

  // Presents an operand set, waits for acceptance, and queues the expected result.
  task automatic send32(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        input logic [31:0] es, input logic ec, input logic eo);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1; a = av; b = bv; cin = cv;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        fail_now("accept_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    e.s = es; e.c = ec; e.o = eo; e.acc = cyc;
    sb32.push_back(e);
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'b0;
  endtask

  task automatic drain32();
    int n = 0;
    while (sb32.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb32.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] full;
    logic [31:0] ra, rb;
    logic        rc;
    exp_t        e4;
    int          n;

    // Reset held for three cycles, then released between edges.
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    @(posedge clk); #1;

    dir_rdy = 1'b1;
    send32(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    drain32();

    // Result held under backpressure while new operands are offered.
    dir_rdy = 1'b0;
    send32(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("bp_valid_timeout");
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'hAAAA_AAAA; b = 32'h5555_5555; cin = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_sum", 64'(sum), 64'h8);
      chk("bp_cout", 64'(cout), 64'(0));
      chk("bp_ovf", 64'(ovf), 64'(0));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      @(posedge clk); #1;
    end
    dir_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_next", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    e4.s = 32'h0000_0000; e4.c = 1'b1; e4.o = 1'b0; e4.acc = cyc;
    sb32.push_back(e4);
    in_valid = 1'b0;
    drain32();

    send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    drain32();

    // Asynchronous reset at k=3 discards the operation.
    send32(32'hFFFF_0000, 32'h0000_0001, 1'b0, 32'hFFFF_0001, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_sum", 64'(sum), 64'(0));
    chk("arst_cout", 64'(cout), 64'(0));
    chk("arst_ovf", 64'(ovf), 64'(0));
    sb32.delete();
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send32(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);
    drain32();

    // Random operands against a full-width behavioural adder.
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      ra = $urandom; rb = $urandom; rc = 1'(($urandom_range(0, 1)));
      full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      send32(ra, rb, rc, full[31:0], full[32],
             (ra[31] == rb[31]) && (full[31] != ra[31]));
    end
    drain32();
    rnd_mode = 1'b0;

    // Single-nibble instance.
    in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1;
    @(negedge clk);
    chk("w4_in_ready", 64'(in_ready4), 64'(1));
    @(posedge clk); #1;
    e4.s = 32'h1; e4.c = 1'b1; e4.o = 1'b0; e4.acc = cyc;
    sb4.push_back(e4);
    in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    n = 0;
    while (sb4.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb4.size() != 0) fail_now("w4_timeout");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
